// File: rtl/ysyx_23060096_pkg.sv
// Shared constants, ALU op codes and the result-buffer entry
// used by the execute stage and its ALU.
package ysyx_23060096_pkg;
    localparam int XLEN = 32;
    localparam int RW   = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_LT  = 3'b110;
    localparam logic [2:0] ALU_EQ  = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [RW-1:0]   rd;
        logic            wen;
    } entry_t;
endpackage

// File: rtl/ysyx_23060096_alu.sv
// Combinational ALU; lt is the signed compare taken from the
// full-width difference sign corrected by overflow.
module ysyx_23060096_alu
    import ysyx_23060096_pkg::*;
(
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o
);
    logic [XLEN-1:0] diff;
    logic            ovf;
    logic            lt;

    assign diff = a_i - b_i;
    assign ovf  = (a_i[XLEN-1] ^ b_i[XLEN-1]) & (a_i[XLEN-1] ^ diff[XLEN-1]);
    assign lt   = diff[XLEN-1] ^ ovf;

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = diff;
            ALU_NOT: result_o = ~a_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_LT:  result_o = {{(XLEN-1){1'b0}}, lt};
            ALU_EQ:  result_o = {{(XLEN-1){1'b0}}, a_i == b_i};
            default: result_o = '0;
        endcase
    end
endmodule

// File: rtl/ysyx_23060096_exu.sv
// Execute stage: ALU plus a small result FIFO decoupling IDU issue
// from WBU back-pressure, with a retired-op counter.
module ysyx_23060096_exu
    import ysyx_23060096_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic [RW-1:0]   in_rd,
    input  logic            in_wen,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RW-1:0]   out_rd,
    output logic            out_wen,
    output logic [31:0]     retired
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     retired_q;
    entry_t          mem_q [DEPTH];
    entry_t          last_q;
    entry_t          head;
    entry_t          shown;
    logic [XLEN-1:0] alu_res;
    logic            push, pop;
    logic            unused_op;

    assign unused_op = in_op[3];

    ysyx_23060096_alu u_alu (
        .op_i    (in_op[2:0]),
        .a_i     (in_src1),
        .b_i     (in_src2),
        .result_o(alu_res)
    );

    assign in_ready  = count_q < CW'(DEPTH);
    assign out_valid = count_q != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // When empty the outputs keep showing the most recently popped entry.
    assign head       = mem_q[rd_ptr_q];
    assign shown      = out_valid ? head : last_q;
    assign out_result = shown.result;
    assign out_rd     = shown.rd;
    assign out_wen    = shown.wen;
    assign retired    = retired_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            retired_q <= '0;
            last_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{result: alu_res, rd: in_rd,
                                     wen: in_wen && (in_rd != '0)};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + PW'(1);
                retired_q <= retired_q + 32'd1;
                last_q    <= head;
            end
            count_q <= count_d;
        end
    end
endmodule

// File: doc/ysyx_23060096_exu.md
Name: ysyx_23060096_exu

Overview:
- Execute-stage wrapper that sits between the IDU and the WBU in the NPC pipeline.
- Accepts decoded ALU requests (op, operands, destination) over a valid/ready handshake and evaluates them through the team's combinational ALU.
- Buffers results in a 2-entry skid FIFO and issues them to the WBU over a second valid/ready handshake.
- Decouples IDU issue from WBU back-pressure and keeps a retired-op counter.

Parameters:
- XLEN, 32, operand/result width
- RW, 5, register index width
- DEPTH, 2, result buffer entries (power of two, at least 2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  IDU request valid
- in_ready  out  1  EXU can accept this cycle
- in_op  in  4  ALU op: [2:0] selects add/sub/not/and/or/xor/lt/eq (000..111); [3] reserved, ignored
- in_src1  in  XLEN  operand A
- in_src2  in  XLEN  operand B
- in_rd  in  RW  destination register
- in_wen  in  1  register write request
- out_valid  out  1  result available to WBU
- out_ready  in  1  WBU accepts
- out_result  out  XLEN  ALU result
- out_rd  out  RW  destination register
- out_wen  out  1  write enable, forced 0 when rd==0
- retired  out  32  count of results accepted by WBU

Behaviour:
- Reset (rst_n low, asynchronous):
  - count=0, wr_ptr=0, rd_ptr=0.
  - out_valid=0, out_result=0, out_rd=0, out_wen=0.
  - retired=0.
  - in_ready=1 after release.
- Push condition: in_valid && in_ready. The ALU result is computed combinationally the same cycle and written with rd/wen into entry wr_ptr at the clock edge.
- Latency: request accepted at edge N is visible on out_* after edge N (1 cycle) when the buffer was empty.
- in_ready = (count < DEPTH). Combinational from state only, never from in_valid or out_ready.
- Pop condition: out_valid && out_ready. rd_ptr advances and retired increments (wraps modulo 2^32).
- out_valid = (count != 0). out_* are driven from entry rd_ptr and stay stable while out_valid && !out_ready.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full (count==DEPTH): in_ready=0. A pop in the same cycle does not enable a push; in_ready rises the next cycle.
- Empty: out_valid=0, and out_* hold the last popped entry's values.
- Pointer wrap: modulo DEPTH.
- wen gating: stored wen = in_wen && (in_rd != 0).
- flush: count, wr_ptr and rd_ptr are cleared at the edge. A push or pop in that cycle is discarded and retired does not increment. flush takes priority over everything except reset.
- Arithmetic:
  - add/sub wrap modulo 2^XLEN.
  - lt returns signed A<B as 0/1 computed from the full-width difference sign and overflow (not a partial bit).
  - eq returns 1 iff A==B.
  - Results are zero-extended to XLEN.
- Reset mid-transfer: all buffered entries are lost and out_valid drops asynchronously.

Decomposition:
- Shared package ysyx_23060096_pkg holds:
  - ALU op localparams (ALU_ADD=3'b000 .. ALU_EQ=3'b111).
  - XLEN and RW constants.
  - The packed result-entry struct {result, rd, wen}.
- One sub-module: ysyx_23060096_alu instantiated for computation, with the lt/eq path corrected per the arithmetic rule above.
- The FIFO stays inline.

Test Plan:
- Reset, then in_valid=1, op=000, src1=0x7FFFFFFF, src2=1, rd=3, wen=1 -> next cycle out_valid=1, out_result=0x80000000, out_rd=3, out_wen=1; retired=1 after out_ready handshake.
- op=110, src1=0xFFFFFFFF (-1), src2=1 -> out_result=1. Then src1=0x80000000, src2=0x7FFFFFFF -> out_result=1. Then src1=5, src2=0x10 -> out_result=1. Then src1=0x10, src2=5 -> out_result=0.
- Hold out_ready=0 and push 3 requests -> first 2 accepted, in_ready=0 from the cycle after the 2nd push, third held. Raise out_ready -> results pop in order; in_ready returns 1 the cycle after the first pop; the third request lands and all 3 retire in order.
- Continuous in_valid and out_ready=1 for 100 cycles with random ops -> throughput of 1 result/cycle, every result matches the reference model, retired=100.
- Push op=111, src1=src2=0x1234, rd=0, wen=1 -> out_result=1, out_wen=0.
- Buffer holding 2 entries, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, retired unchanged. Separately, assert rst_n=0 mid-stream -> out_valid falls without waiting for a clock edge.
